// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: run/redirect control, instruction memory port, decode-side output.
// master = fetch_sequencer side, slave = the environment (memory, decode, control).
// Optional perf counters are present only when FETCH_SEQ_PERF_EN is defined.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int INST_WIDTH = 32
);
  logic                  run;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [INST_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  idle;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]           perf_stall_cycles;
  logic [31:0]           perf_flushed;
`endif

  modport master (
    input  run, redirect_valid, redirect_addr, mem_data, out_ready,
    output mem_en, mem_addr, out_valid, out_inst, out_pc, idle
`ifdef FETCH_SEQ_PERF_EN
    , output perf_stall_cycles, perf_flushed
`endif
  );

  modport slave (
    output run, redirect_valid, redirect_addr, mem_data, out_ready,
    input  mem_en, mem_addr, out_valid, out_inst, out_pc, idle
`ifdef FETCH_SEQ_PERF_EN
    , input perf_stall_cycles, perf_flushed
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one instruction-memory read per cycle, buffers returns in a FIFO.
// Latency: issue at t -> out_valid at t+MEM_LATENCY+1; redirect at t -> new instruction at t+2*MEM_LATENCY+2.
// Backpressure: reads issue only while fifo_count+inflight < FIFO_DEPTH; optional perf counters under FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INST_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FL_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [MEM_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [ADDR_WIDTH-1:0] dl_addr_q [MEM_LATENCY];
  logic [ADDR_WIDTH-1:0] dl_addr_d [MEM_LATENCY];
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [CNT_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Credit accounting: every valid delay-line stage has a reserved FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(dl_vld_q[i]);
    end
    credit_ok = ({1'b0, count_q} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    issue     = (state_q == FETCH) && bus.run && credit_ok && !bus.redirect_valid;
    push      = dl_vld_q[MEM_LATENCY-1];
    pop       = (count_q != '0) && bus.out_ready;
  end

  // Control FSM: redirect from any state wins and restarts the flush window.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_addr;
      flush_cnt_d = FL_W'(MEM_LATENCY);
      state_d     = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) state_d = FETCH;
        end
        FETCH: begin
          if (issue) pc_d = pc_q + ADDR_WIDTH'(1);
          if (!bus.run) state_d = IDLE;
        end
        FLUSH: begin
          // Leaving on the last count keeps the first new issue at redirect+MEM_LATENCY+1.
          if (flush_cnt_q <= FL_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = bus.run ? FETCH : IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - FL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-latency delay line tagging each outstanding read with its address; redirect kills all stages.
  always_comb begin
    dl_addr_d    = dl_addr_q;
    dl_vld_d     = '0;
    dl_vld_d[0]  = issue;
    dl_addr_d[0] = pc_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
    if (bus.redirect_valid) dl_vld_d = '0;
  end

  // Output FIFO: push from delay-line tail, pop on handshake; redirect empties it after any same-cycle pop.
  always_comb begin
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = bus.mem_data;
        fifo_pc_d[wr_ptr_q]   = dl_addr_q[MEM_LATENCY-1];
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]    perf_stall_q, perf_stall_d;
  logic [31:0]    perf_flushed_q, perf_flushed_d;
  logic [CNT_W:0] discard;
  logic [32:0]    flushed_sum;

  // Saturating counters: credit-stall cycles and entries thrown away by redirects.
  always_comb begin
    perf_stall_d   = perf_stall_q;
    perf_flushed_d = perf_flushed_q;
    discard        = {1'b0, count_q} - (CNT_W + 1)'(pop) + {1'b0, inflight};
    flushed_sum    = {1'b0, perf_flushed_q} + 33'(discard);
    if ((state_q == FETCH) && bus.run && !credit_ok && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (bus.redirect_valid) begin
      perf_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushed      = perf_flushed_q;
`endif

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      flush_cnt_q <= '0;
      dl_vld_q    <= '0;
      dl_addr_q   <= '{default: '0};
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
`ifdef FETCH_SEQ_PERF_EN
      perf_stall_q   <= '0;
      perf_flushed_q <= '0;
`endif
    end else begin
      assert (!(push && !bus.redirect_valid && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      dl_vld_q    <= dl_vld_d;
      dl_addr_q   <= dl_addr_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
`ifdef FETCH_SEQ_PERF_EN
      perf_stall_q   <= perf_stall_d;
      perf_flushed_q <= perf_flushed_d;
`endif
    end
  end

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = fifo_inst_q[rd_ptr_q];
  assign bus.out_pc    = fifo_pc_q[rd_ptr_q];
  assign bus.idle      = (state_q == IDLE) && (inflight == '0) && (count_q == '0);
endmodule
